tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter LOCK_TOKENS, default 8: consecutive valid control tokens required to declare lock.
REQ-002 SHALL have parameter UNLOCK_ERRS, default 4: consecutive invalid characters that drop lock.
REQ-003 SHALL have parameter SEARCH_WINDOW, default 1024: valid words searched without lock before a bit-slip request.
REQ-004 SHALL have parameter SLIP_WAIT, default 16: cycles ignored after a bit-slip request.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 q_in  input  10  received TMDS character, q_in[0] first bit on wire.
REQ-008 q_valid  input  1  q_in valid this cycle.
REQ-009 D  output  8  decoded pixel/data byte.
REQ-010 DE  output  1  data enable: 1 = data character, 0 = control period.
REQ-011 C1, C0  output  1 each  control bits (C0 = hsync, C1 = vsync on channel 0).
REQ-012 out_valid  output  1  D/DE/C1/C0 valid this cycle.
REQ-013 locked  output  1  word alignment achieved.
REQ-014 bitslip  output  1  one-cycle request to the deserializer to shift alignment by one bit.
REQ-015 err_code  output  1  one-cycle pulse: invalid character received while locked.

Function
REQ-016 Pipeline SHALL be two registered stages; out_valid SHALL equal q_valid delayed exactly 2 cycles.
REQ-017 Control tokens (HDMI table) SHALL map {C1,C0}: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11, and set DE=0, D=0.
REQ-018 Any other word SHALL decode as data, DE=1: d = q[9] ? ~q[7:0] : q[7:0]; D[0]=d[0]; D[i] = q[8] ? d[i]^d[i-1] : d[i]~^d[i-1] for i=1..7; C1/C0 hold last control value.
REQ-019 A data word SHALL be invalid when q[7:0] has more than 4 adjacent-bit transitions (q[i]!=q[i+1], i=0..6).
REQ-020 FSM states SEARCH, SLIP, LOCKED; classification SHALL use stage-2 words; q_valid=0 cycles SHALL hold all counters.
REQ-021 SEARCH: consecutive-token counter increments per control token, clears on any data word; at LOCK_TOKENS -> LOCKED, locked=1 on the same cycle out_valid presents that token.
REQ-022 SEARCH: window counter increments per valid word; at SEARCH_WINDOW without lock -> bitslip=1 for one cycle, -> SLIP.
REQ-023 SLIP: ignore input for SLIP_WAIT cycles, clear counters, -> SEARCH; out_valid continues per REQ-016.
REQ-024 LOCKED: invalid word pulses err_code and increments error counter; any valid word clears it; at UNLOCK_ERRS -> SEARCH, locked=0 next cycle.
REQ-025 err_code SHALL never assert outside LOCKED.

Reset
REQ-026 rst SHALL, next edge, force D=0, DE=0, C1=C0=0, out_valid=0, locked=0, bitslip=0, err_code=0, state SEARCH, all counters and pipeline valids 0, regardless of state.

Configuration
REQ-027 With LEGACY_DVI_CONTROL_LUT_EN defined, control table SHALL be 0010101011->00, 1101010100->01, 0010101010->10, 1101010101->11; without it, the HDMI table of REQ-017 SHALL apply.

Structure
REQ-028 Package tmds_pkg SHALL hold both control-token tables, the FSM state enum, and the word-width constant (10).
REQ-029 Sub-module tmds_char_decode SHALL be combinational: classify (control/data/invalid) and decode one word.

Verification
REQ-030 rst, then 8 valid 1101010100 -> locked=1 with 8th output; DE=0, C1C0=00, latency 2.
REQ-031 Locked, 0100000000 then 1000000000 -> D=0x00 then D=0xFF, DE=1, out_valid 2 cycles after each input.
REQ-032 Locked, 4x 0001010101 -> err_code pulses 4 times, locked=0 after 4th; one valid word in between resets count, lock held.
REQ-033 From reset, 1024 data words without tokens -> single bitslip pulse, next 16 cycles' inputs ignored, then lock from 8 tokens.
REQ-034 rst asserted while LOCKED mid-data -> all outputs 0 next cycle, locked needs 8 new tokens.
REQ-035 0010101011 control -> C1C0=01 without macro, 00 with LEGACY_DVI_CONTROL_LUT_EN.

Source files
------------

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants, control-token tables and enums for the TMDS decoder.
// Revision 1.0 - initial release.
`default_nettype none

package tmds_pkg;

  localparam int C_WORD_W = 10;

  // Entry k is the token that decodes to {C1,C0} = k.
  localparam logic [3:0][C_WORD_W-1:0] C_HDMI_CTRL_LUT = {
    10'b1010101011, 10'b0101010100, 10'b0010101011, 10'b1101010100
  };

  localparam logic [3:0][C_WORD_W-1:0] C_DVI_CTRL_LUT = {
    10'b1101010101, 10'b0010101010, 10'b1101010100, 10'b0010101011
  };

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } tmds_state_e;

  typedef enum logic [1:0] {
    CLS_CTRL    = 2'd0,
    CLS_DATA    = 2'd1,
    CLS_INVALID = 2'd2
  } char_class_e;

endpackage

`default_nettype wire

// File: rtl/tmds_char_decode.sv
// tmds_char_decode: combinational classify/decode of one TMDS word.
// LEGACY_DVI_CONTROL_LUT_EN selects the legacy DVI control table. Revision 1.0.
`default_nettype none

module tmds_char_decode
  import tmds_pkg::*;
(
  input  logic [C_WORD_W-1:0] word,
  output char_class_e         cls,
  output logic [7:0]          data,
  output logic [1:0]          ctrl
);

`ifdef LEGACY_DVI_CONTROL_LUT_EN
  localparam logic [3:0][C_WORD_W-1:0] CTRL_LUT = C_DVI_CTRL_LUT;
`else
  localparam logic [3:0][C_WORD_W-1:0] CTRL_LUT = C_HDMI_CTRL_LUT;
`endif

  logic [7:0] d;
  logic [2:0] trans;

  always_comb begin
    cls   = CLS_DATA;
    ctrl  = 2'b00;
    data  = 8'h00;
    trans = 3'd0;
    d     = word[9] ? ~word[7:0] : word[7:0];
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    for (int i = 0; i < 7; i++) begin
      trans = trans + {2'b00, word[i] ^ word[i+1]};
    end
    if (trans > 3'd4) begin
      cls = CLS_INVALID;
    end
    // Control tokens win over the transition rule: they are deliberately transition-rich.
    for (int k = 0; k < 4; k++) begin
      if (word == CTRL_LUT[k]) begin
        cls  = CLS_CTRL;
        ctrl = 2'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tmds_decoder.sv
// tmds_decoder: two-stage TMDS character decoder with word-alignment FSM and bit-slip requests.
// Build option LEGACY_DVI_CONTROL_LUT_EN (see tmds_char_decode). Revision 1.0.
`default_nettype none

module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 8,
  parameter int UNLOCK_ERRS   = 4,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_WORD_W-1:0] q_in,
  input  logic                q_valid,
  output logic [7:0]          D,
  output logic                DE,
  output logic                C1,
  output logic                C0,
  output logic                out_valid,
  output logic                locked,
  output logic                bitslip,
  output logic                err_code
);

  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int ERR_W  = $clog2(UNLOCK_ERRS + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  logic [C_WORD_W-1:0] s1_word_q, s1_word_d;
  logic                s1_valid_q, s1_valid_d;
  logic [7:0]          data_q, data_d;
  logic                de_q, de_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic                out_valid_q, out_valid_d;
  logic                locked_q, locked_d;
  logic                bitslip_q, bitslip_d;
  logic                err_code_q, err_code_d;
  tmds_state_e         state_q, state_d;
  logic [TOK_W-1:0]    tok_cnt_q, tok_cnt_d, tok_next;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d, win_next;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d, err_next;
  logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;

  char_class_e dec_cls;
  logic [7:0]  dec_data;
  logic [1:0]  dec_ctrl;

  tmds_char_decode u_char_decode (
    .word (s1_word_q),
    .cls  (dec_cls),
    .data (dec_data),
    .ctrl (dec_ctrl)
  );

  // The FSM classifies the stage-1 word on the same edge that registers it as stage 2,
  // so locked/err_code/bitslip line up with out_valid of the word that caused them.
  always_comb begin
    s1_word_d   = q_in;
    s1_valid_d  = q_valid;
    out_valid_d = s1_valid_q;
    data_d      = data_q;
    de_d        = de_q;
    ctrl_d      = ctrl_q;
    state_d     = state_q;
    locked_d    = locked_q;
    bitslip_d   = 1'b0;
    err_code_d  = 1'b0;
    tok_cnt_d   = tok_cnt_q;
    win_cnt_d   = win_cnt_q;
    err_cnt_d   = err_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    tok_next    = tok_cnt_q + 1'b1;
    win_next    = win_cnt_q + 1'b1;
    err_next    = err_cnt_q + 1'b1;

    if (s1_valid_q) begin
      if (dec_cls == CLS_CTRL) begin
        data_d = 8'h00;
        de_d   = 1'b0;
        ctrl_d = dec_ctrl;
      end else begin
        data_d = dec_data;
        de_d   = 1'b1;
      end
    end

    case (state_q)
      ST_SEARCH: begin
        if (s1_valid_q) begin
          win_cnt_d = win_next;
          tok_cnt_d = (dec_cls == CLS_CTRL) ? tok_next : '0;
          if ((dec_cls == CLS_CTRL) && (tok_next == TOK_W'(LOCK_TOKENS))) begin
            state_d   = ST_LOCKED;
            locked_d  = 1'b1;
            tok_cnt_d = '0;
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else if (win_next == WIN_W'(SEARCH_WINDOW)) begin
            state_d    = ST_SLIP;
            bitslip_d  = 1'b1;
            tok_cnt_d  = '0;
            win_cnt_d  = '0;
            slip_cnt_d = '0;
          end
        end
      end
      ST_SLIP: begin
        if (slip_cnt_q == SLIP_W'(SLIP_WAIT - 1)) begin
          state_d    = ST_SEARCH;
          slip_cnt_d = '0;
        end else begin
          slip_cnt_d = slip_cnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (s1_valid_q) begin
          if (dec_cls == CLS_INVALID) begin
            err_code_d = 1'b1;
            if (err_next == ERR_W'(UNLOCK_ERRS)) begin
              state_d   = ST_SEARCH;
              locked_d  = 1'b0;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_next;
            end
          end else begin
            err_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_word_q   <= '0;
      s1_valid_q  <= 1'b0;
      data_q      <= 8'h00;
      de_q        <= 1'b0;
      ctrl_q      <= 2'b00;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      bitslip_q   <= 1'b0;
      err_code_q  <= 1'b0;
      state_q     <= ST_SEARCH;
      tok_cnt_q   <= '0;
      win_cnt_q   <= '0;
      err_cnt_q   <= '0;
      slip_cnt_q  <= '0;
    end else begin
      s1_word_q   <= s1_word_d;
      s1_valid_q  <= s1_valid_d;
      data_q      <= data_d;
      de_q        <= de_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      bitslip_q   <= bitslip_d;
      err_code_q  <= err_code_d;
      state_q     <= state_d;
      tok_cnt_q   <= tok_cnt_d;
      win_cnt_q   <= win_cnt_d;
      err_cnt_q   <= err_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
    end
  end

  assign D         = data_q;
  assign DE        = de_q;
  assign C1        = ctrl_q[1];
  assign C0        = ctrl_q[0];
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign bitslip   = bitslip_q;
  assign err_code  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed and randomized checks of tmds_decoder against a behavioural model.
// Honours LEGACY_DVI_CONTROL_LUT_EN for the expected control table. Revision 1.0.
`default_nettype none

module tb_tmds_decoder;

  localparam int LOCK_TOKENS   = 8;
  localparam int UNLOCK_ERRS   = 4;
  localparam int SEARCH_WINDOW = 1024;
  localparam int SLIP_WAIT     = 16;

  localparam int M_HUNT = 0;
  localparam int M_WAIT = 1;
  localparam int M_LOCK = 2;

  localparam logic [9:0] TOK00   = 10'b1101010100;
  localparam logic [9:0] TOK01H  = 10'b0010101011;
  localparam logic [9:0] W_ZERO  = 10'b0100000000;
  localparam logic [9:0] W_ONES  = 10'b1000000000;
  localparam logic [9:0] W_BAD   = 10'b0001010101;

  logic       clk;
  logic       rst;
  logic [9:0] q_in;
  logic       q_valid;
  logic [7:0] D;
  logic       DE, C1, C0, out_valid, locked, bitslip, err_code;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int slip_pulses = 0;

  // Behavioural model state
  int         m_mode, m_tok_run, m_words, m_wait_left, m_bad_run;
  logic [7:0] m_D;
  logic       m_DE, m_valid, m_locked, m_bitslip, m_err;
  logic [1:0] m_C;
  logic       pv;
  logic [9:0] pw;

  tmds_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .q_valid   (q_valid),
    .D         (D),
    .DE        (DE),
    .C1        (C1),
    .C0        (C0),
    .out_valid (out_valid),
    .locked    (locked),
    .bitslip   (bitslip),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tok_index(input logic [9:0] w);
`ifdef LEGACY_DVI_CONTROL_LUT_EN
    case (w)
      10'b0010101011: return 0;
      10'b1101010100: return 1;
      10'b0010101010: return 2;
      10'b1101010101: return 3;
      default:        return -1;
    endcase
`else
    case (w)
      10'b1101010100: return 0;
      10'b0010101011: return 1;
      10'b0101010100: return 2;
      10'b1010101011: return 3;
      default:        return -1;
    endcase
`endif
  endfunction

  function automatic int edge_count(input logic [9:0] w);
    logic [7:0] b;
    b = w[7:0];
    return $countones((b ^ (b >> 1)) & 8'h7F);
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d, o;
    d = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~w[8];
    return o;
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_tok_run = 0; m_words = 0; m_wait_left = 0; m_bad_run = 0;
    m_D = 8'h00; m_DE = 1'b0; m_C = 2'b00;
    m_valid = 1'b0; m_locked = 1'b0; m_bitslip = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [9:0] w);
    int mode_now, idx;
    logic bad;
    mode_now  = m_mode;
    idx       = tok_index(w);
    bad       = (idx < 0) && (edge_count(w) > 4);
    m_valid   = v;
    m_bitslip = 1'b0;
    m_err     = 1'b0;
    if (v) begin
      if (idx >= 0) begin
        m_D = 8'h00; m_DE = 1'b0; m_C = 2'(idx);
      end else begin
        m_D = ref_decode(w); m_DE = 1'b1;
      end
    end
    if (mode_now == M_WAIT) begin
      m_wait_left--;
      if (m_wait_left == 0) m_mode = M_HUNT;
    end else if (mode_now == M_HUNT && v) begin
      m_words++;
      m_tok_run = (idx >= 0) ? m_tok_run + 1 : 0;
      if (m_tok_run == LOCK_TOKENS) begin
        m_mode = M_LOCK; m_locked = 1'b1; m_tok_run = 0; m_words = 0; m_bad_run = 0;
      end else if (m_words == SEARCH_WINDOW) begin
        m_mode = M_WAIT; m_bitslip = 1'b1; m_wait_left = SLIP_WAIT;
        m_tok_run = 0; m_words = 0;
      end
    end else if (mode_now == M_LOCK && v) begin
      if (bad) begin
        m_err = 1'b1;
        m_bad_run++;
        if (m_bad_run == UNLOCK_ERRS) begin
          m_mode = M_HUNT; m_locked = 1'b0; m_bad_run = 0;
        end
      end else begin
        m_bad_run = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("D",         32'(D),         32'(m_D));
    check("DE",        32'(DE),        32'(m_DE));
    check("C1C0",      32'({C1, C0}),  32'(m_C));
    check("locked",    32'(locked),    32'(m_locked));
    check("bitslip",   32'(bitslip),   32'(m_bitslip));
    check("err_code",  32'(err_code),  32'(m_err));
  endtask

  // One clock: drive inputs, let the edge pass, then compare the word driven on the previous call.
  task automatic cycle(input logic r, input logic v, input logic [9:0] w);
    rst = r; q_valid = v; q_in = w;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      pv = 1'b0; pw = '0;
    end else begin
      model_step(pv, pw);
      pv = v; pw = w;
    end
    err_pulses  += int'(err_code);
    slip_pulses += int'(bitslip);
    compare_all();
  endtask

  task automatic send(input int n, input logic [9:0] w);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, w);
  endtask

  function automatic logic [9:0] rand_word();
    int r;
    logic [9:0] w;
    r = $urandom_range(0, 9);
    if (r < 3) begin
      case ($urandom_range(0, 3))
        0: w = 10'b1101010100;
        1: w = 10'b0010101011;
        2: w = 10'b0101010100;
        default: w = 10'b1010101011;
      endcase
    end else if (r < 7) begin
      w = 10'($urandom);
      for (int t = 0; t < 16 && edge_count(w) > 4; t++) w = 10'($urandom);
    end else begin
      w = 10'($urandom);
    end
    return w;
  endfunction

  initial begin
    rst = 1'b1; q_valid = 1'b0; q_in = '0;
    pv = 1'b0; pw = '0;
    model_reset();

    // Reset state
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, TOK00);
    check("rst_D", 32'(D), 32'h0);
    check("rst_outvalid", 32'(out_valid), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);

    // Lock after 8 tokens, presented with the 8th token's output
    send(LOCK_TOKENS, TOK00);
    check("lock_before_8th", 32'(locked), 32'h0);
    cycle(1'b0, 1'b0, '0);
    check("lock_on_8th", 32'(locked), 32'h1);
    check("lock_DE", 32'(DE), 32'h0);
    check("lock_C1C0", 32'({C1, C0}), 32'h0);
    check("lock_outvalid", 32'(out_valid), 32'h1);

    // Data decode extremes
    cycle(1'b0, 1'b1, W_ZERO);
    cycle(1'b0, 1'b1, W_ONES);
    check("d00_D", 32'(D), 32'h00);
    check("d00_DE", 32'(DE), 32'h1);
    cycle(1'b0, 1'b0, '0);
    check("dff_D", 32'(D), 32'hFF);
    check("dff_outvalid", 32'(out_valid), 32'h1);
    cycle(1'b0, 1'b0, '0);
    check("idle_outvalid", 32'(out_valid), 32'h0);

    // Error run broken by a valid word, then four in a row
    err_pulses = 0;
    send(3, W_BAD);
    send(1, W_ZERO);
    send(4, W_BAD);
    cycle(1'b0, 1'b0, '0);
    check("err_pulses", 32'(err_pulses), 32'd7);
    check("unlock_after_4", 32'(locked), 32'h0);

    // Reset while locked mid-data
    send(LOCK_TOKENS, TOK00);
    send(3, W_ONES);
    check("relock", 32'(locked), 32'h1);
    cycle(1'b1, 1'b1, W_ZERO);
    check("midrst_D", 32'(D), 32'h0);
    check("midrst_DE", 32'(DE), 32'h0);
    check("midrst_locked", 32'(locked), 32'h0);
    send(LOCK_TOKENS, TOK00);
    check("midrst_7tok", 32'(locked), 32'h0);
    cycle(1'b0, 1'b0, '0);
    check("midrst_8tok", 32'(locked), 32'h1);

    // Search window exhaustion and bit-slip hold-off
    cycle(1'b1, 1'b0, '0);
    slip_pulses = 0;
    send(SEARCH_WINDOW, W_ZERO);
    send(SLIP_WAIT + LOCK_TOKENS - 1, TOK00);
    cycle(1'b0, 1'b0, '0);
    check("slip_once", 32'(slip_pulses), 32'd1);
    check("slip_ignored", 32'(locked), 32'h0);
    send(1, TOK00);
    cycle(1'b0, 1'b0, '0);
    check("slip_relock", 32'(locked), 32'h1);

    // Control table selection
    send(1, TOK01H);
    cycle(1'b0, 1'b0, '0);
`ifdef LEGACY_DVI_CONTROL_LUT_EN
    check("ctl_table", 32'({C1, C0}), 32'h0);
`else
    check("ctl_table", 32'({C1, C0}), 32'h1);
`endif

    // Randomized traffic with occasional token bursts and gaps
    cycle(1'b1, 1'b0, '0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        send(LOCK_TOKENS + 1, TOK00);
      end else begin
        cycle(1'b0, ($urandom_range(0, 4) != 0), rand_word());
      end
    end
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
